// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for the bit-serial subtractor: operands and start
// flow from master to slave, status and result flow back.
interface serial_subtractor_if #(
    parameter int data_width = 8
);
    logic                  start;
    logic [data_width-1:0] A;
    logic [data_width-1:0] B;
    logic                  BIN;
    logic                  busy;
    logic                  done;
    logic [data_width-1:0] DIFF;
    logic                  BOUT;
    logic                  OVF;

    modport master (
        output start, A, B, BIN,
        input  busy, done, DIFF, BOUT, OVF
    );

    modport slave (
        input  start, A, B, BIN,
        output busy, done, DIFF, BOUT, OVF
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A - B - BIN one bit per clock, LSB first,
// and publishes DIFF, BOUT and OVF together with a one-cycle done pulse.
module serial_subtractor #(
    parameter int data_width = 8
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave bus
);
    localparam int cnt_w = (data_width > 2) ? $clog2(data_width) : 1;

    typedef logic [cnt_w-1:0] cnt_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam cnt_t cnt_last = cnt_t'(data_width - 1);

    state_t                state_q, state_d;
    logic [data_width-1:0] a_q, a_d;
    logic [data_width-1:0] b_q, b_d;
    logic [data_width-1:0] res_q, res_d;
    logic [data_width-1:0] diff_q, diff_d;
    logic                  br_q, br_d;
    logic                  bout_q, bout_d;
    logic                  ovf_q, ovf_d;
    cnt_t                  cnt_q, cnt_d;

    logic bit_a;
    logic bit_b;
    logic bit_d;
    logic bit_br;

    assign bit_a  = a_q[0];
    assign bit_b  = b_q[0];
    assign bit_d  = bit_a ^ bit_b ^ br_q;
    assign bit_br = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);

    // NOTE: every _d gets its hold value first so no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    br_d    = bus.BIN;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = bit_br;
                res_d = {bit_d, res_q[data_width-1:1]};
                if (cnt_q == cnt_last) begin
                    // On the MSB step br_q is the borrow into the MSB.
                    diff_d  = {bit_d, res_q[data_width-1:1]};
                    bout_d  = bit_br;
                    ovf_d   = br_q ^ bit_br;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            // NOTE: the operand shift registers are cleared as well, so an
            // aborted operation leaves no stale operand bits behind.
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.DIFF = diff_q;
    assign bus.BOUT = bout_q;
    assign bus.OVF  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vectors, random operands,
// ignored starts, reset abort and back-to-back issue against an arithmetic model.
module tb_serial_subtractor;
    localparam int dw = 8;

    logic clk = 1'b0;
    logic rst;

    int total = 0;
    int bad   = 0;

    logic [dw-1:0] exp_diff;
    logic          exp_bout;
    logic          exp_ovf;

    always #5 clk = ~clk;

    serial_subtractor_if #(.data_width(dw)) bus ();

    serial_subtractor #(.data_width(dw)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Plain integer arithmetic: unsigned difference, unsigned compare, signed range.
    task automatic model(input logic [dw-1:0] a, input logic [dw-1:0] b, input logic bin,
                         output logic [dw-1:0] d, output logic bo, output logic ov);
        int ua, ub, sa, sb, r, rs;
        ua = int'(a);
        ub = int'(b);
        r  = ua - ub - int'(bin);
        d  = r[dw-1:0];
        bo = (ua < ub + int'(bin));
        sa = a[dw-1] ? ua - (1 << dw) : ua;
        sb = b[dw-1] ? ub - (1 << dw) : ub;
        rs = sa - sb - int'(bin);
        ov = (rs < -(1 << (dw - 1))) || (rs > (1 << (dw - 1)) - 1);
    endtask

    function automatic logic [dw+3:0] observed();
        return {bus.busy, bus.done, bus.DIFF, bus.BOUT, bus.OVF};
    endfunction

    // One full operation; checks busy/done/outputs after every edge from E0 to E_dw+1.
    task automatic run_op(input logic [dw-1:0] a, input logic [dw-1:0] b, input logic bin,
                          input string tag, input bit already_driven);
        logic [dw-1:0] nd;
        logic          nb, no;
        logic [dw+3:0] want;
        model(a, b, bin, nd, nb, no);
        if (!already_driven) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.A     = a;
            bus.B     = b;
            bus.BIN   = bin;
        end
        @(posedge clk);
        for (int k = 0; k <= dw + 1; k++) begin
            if (k > 0) @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
            bus.A     = dw'($urandom);
            bus.B     = dw'($urandom);
            bus.BIN   = 1'($urandom);
            if (k < dw)       want = {2'b10, exp_diff, exp_bout, exp_ovf};
            else if (k == dw) want = {2'b01, nd, nb, no};
            else              want = {2'b00, nd, nb, no};
            total++;
            if (observed() !== want) begin
                bad++;
                $display("FAIL %s a=%h b=%h bin=%b k=%0d: got busy,done,diff,bout,ovf=%b want %b",
                         tag, a, b, bin, k, observed(), want);
            end
            if (k == dw) begin
                exp_diff = nd;
                exp_bout = nb;
                exp_ovf  = no;
            end
        end
    endtask

    task automatic test_reset();
        logic [dw-1:0] a, b;
        @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b1;
        exp_diff  = '0;
        exp_bout  = 1'b0;
        exp_ovf   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (observed() !== '0) begin
                bad++;
                $display("FAIL reset_hold k=%0d: got %b want all zero", k, observed());
            end
        end
        a         = dw'($urandom);
        b         = dw'($urandom);
        rst       = 1'b0;
        bus.A     = a;
        bus.B     = b;
        bus.BIN   = 1'b1;
        run_op(a, b, 1'b1, "reset_release_start", 1'b1);
    endtask

    task automatic test_directed();
        run_op(8'h05, 8'h03, 1'b0, "dir_5_3", 1'b0);
        run_op(8'h00, 8'h01, 1'b0, "dir_0_1", 1'b0);
        run_op(8'h80, 8'h01, 1'b0, "dir_80_1", 1'b0);
        run_op(8'h7F, 8'hFF, 1'b0, "dir_7f_ff", 1'b0);
        run_op(8'h10, 8'h0F, 1'b1, "dir_10_0f_bin", 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, "dir_ff_ff_bin", 1'b0);
        run_op(8'h00, 8'hFF, 1'b1, "dir_0_ff_bin", 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++)
            run_op(dw'($urandom), dw'($urandom), 1'($urandom), "random", 1'b0);
    endtask

    task automatic test_ignore_start();
        logic [dw-1:0] a, b, nd;
        logic          bin, nb, no;
        logic [dw+3:0] want;
        int            pulses;
        a      = dw'($urandom);
        b      = dw'($urandom);
        bin    = 1'($urandom);
        pulses = 0;
        model(a, b, bin, nd, nb, no);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.BIN   = bin;
        @(posedge clk);
        for (int k = 0; k <= dw + 3; k++) begin
            if (k > 0) @(posedge clk);
            @(negedge clk);
            bus.start = (k == 2);
            bus.A     = ~a;
            bus.B     = ~b;
            bus.BIN   = ~bin;
            if (bus.done === 1'b1) pulses++;
            if (k < dw)       want = {2'b10, exp_diff, exp_bout, exp_ovf};
            else if (k == dw) want = {2'b01, nd, nb, no};
            else              want = {2'b00, nd, nb, no};
            total++;
            if (observed() !== want) begin
                bad++;
                $display("FAIL ignore_start k=%0d: got %b want %b", k, observed(), want);
            end
            if (k == dw) begin
                exp_diff = nd;
                exp_bout = nb;
                exp_ovf  = no;
            end
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL ignore_start_pulses: got %0d done pulses want 1", pulses);
        end
    endtask

    task automatic test_reset_abort();
        logic [dw+3:0] want;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = dw'($urandom);
        bus.B     = dw'($urandom);
        bus.BIN   = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
            want = {2'b10, exp_diff, exp_bout, exp_ovf};
            total++;
            if (observed() !== want) begin
                bad++;
                $display("FAIL abort_pre k=%0d: got %b want %b", k, observed(), want);
            end
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        exp_diff = '0;
        exp_bout = 1'b0;
        exp_ovf  = 1'b0;
        total++;
        if (observed() !== '0) begin
            bad++;
            $display("FAIL abort_reset: got %b want all zero", observed());
        end
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (observed() !== '0) begin
                bad++;
                $display("FAIL abort_quiet k=%0d: got %b want all zero", k, observed());
            end
        end
        run_op(dw'($urandom), dw'($urandom), 1'($urandom), "after_abort", 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [dw-1:0] pa [6];
        logic [dw-1:0] pb [6];
        logic          pbin [6];
        logic [dw-1:0] nd;
        logic          nb, no;
        logic [dw+3:0] want;
        int            ph, op;
        for (int i = 0; i < 6; i++) begin
            pa[i]   = dw'($urandom);
            pb[i]   = dw'($urandom);
            pbin[i] = 1'($urandom);
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = pa[0];
        bus.B     = pb[0];
        bus.BIN   = pbin[0];
        for (int t = 1; t <= 5 * (dw + 2); t++) begin
            @(posedge clk);
            @(negedge clk);
            ph = (t - 1) % (dw + 2);
            op = (t - 1) / (dw + 2);
            if (ph == 0) begin
                bus.A   = pa[op+1];
                bus.B   = pb[op+1];
                bus.BIN = pbin[op+1];
            end
            if (ph == dw) begin
                model(pa[op], pb[op], pbin[op], nd, nb, no);
                exp_diff = nd;
                exp_bout = nb;
                exp_ovf  = no;
            end
            want = {(ph < dw), (ph == dw), exp_diff, exp_bout, exp_ovf};
            total++;
            if (observed() !== want) begin
                bad++;
                $display("FAIL back_to_back op=%0d phase=%0d: got %b want %b", op, ph, observed(), want);
            end
        end
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL back_to_back_stop: got busy=%b want 0", bus.busy);
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.BIN   = 1'b0;
        exp_diff  = '0;
        exp_bout  = 1'b0;
        exp_ovf   = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter data_width, default 8, giving the operand and result width in bits (minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port A, input, data_width bits: minuend, captured on the accepting edge.
REQ-006 The block SHALL have port B, input, data_width bits: subtrahend, captured on the accepting edge.
REQ-007 The block SHALL have port BIN, input, 1 bit: borrow-in, captured on the accepting edge.
REQ-008 The block SHALL have port busy, output, 1 bit: high while the operation is in progress (RUN).
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid new result.
REQ-010 The block SHALL have port DIFF, output, data_width bits: registered result A - B - BIN mod 2^data_width.
REQ-011 The block SHALL have port BOUT, output, 1 bit: borrow-out (unsigned A < B + BIN).
REQ-012 The block SHALL have port OVF, output, 1 bit: two's-complement signed overflow of the subtraction.

Function
REQ-013 The FSM SHALL have exactly three states, IDLE, RUN and DONE, and SHALL leave reset in IDLE.
REQ-014 IDLE with start=1 at edge E0 SHALL latch A, B and BIN into internal shift registers and a borrow flop, clear the bit counter and go to RUN; IDLE with start=0 SHALL stay in IDLE.
REQ-015 Each RUN edge SHALL process one bit, LSB first: d = a ^ b ^ br; br_next = (~a & b) | (~(a ^ b) & br).
REQ-016 RUN SHALL last exactly data_width edges (E1..E_dw); the counter SHALL run 0..data_width-1 and not wrap beyond.
REQ-017 At edge E_dw the block SHALL load DIFF with the full assembled result, BOUT with the final borrow, and OVF with (borrow into MSB) XOR (borrow out of MSB), then go to DONE.
REQ-018 DONE SHALL last exactly one cycle with done=1, and the block SHALL return to IDLE unconditionally at edge E_dw+1.
REQ-019 busy SHALL be 1 exactly in RUN and 0 in IDLE and DONE; done SHALL be 1 exactly in DONE.
REQ-020 DIFF, BOUT and OVF SHALL change only at the final RUN edge and SHALL hold their values across IDLE, RUN and DONE until the next completion.
REQ-021 start SHALL be ignored in RUN and DONE, with no queuing; a start held high through DONE SHALL be accepted on the first IDLE edge.
REQ-022 A, B and BIN SHALL be don't-care after E0; input changes during RUN SHALL NOT affect the result.
REQ-023 Minimum issue interval SHALL be data_width+2 cycles, with latency from the accepting edge to done high of data_width+1 edges.

Reset
REQ-024 rst=1 at any edge SHALL force IDLE and clear busy, done, DIFF, BOUT, OVF, the counter, the borrow flop and the shift registers to 0.
REQ-025 Reset SHALL take priority over start and SHALL abort an in-progress RUN or DONE with no done pulse for the aborted operation.
REQ-026 With rst=0 and start=1 on the first edge after reset is released, that start SHALL be accepted normally.

Verification (data_width=8)
REQ-027 A=0x05, B=0x03, BIN=0 -> done 9 edges after the accepting edge; DIFF=0x02, BOUT=0, OVF=0.
REQ-028 A=0x00, B=0x01, BIN=0 -> DIFF=0xFF, BOUT=1, OVF=0; A=0x80, B=0x01 -> DIFF=0x7F, BOUT=0, OVF=1.
REQ-029 A=0x7F, B=0xFF, BIN=0 -> DIFF=0x80, BOUT=1, OVF=1; A=0x10, B=0x0F, BIN=1 -> DIFF=0x00, BOUT=0, OVF=0.
REQ-030 A second start with new operands pulsed at edge E3 of a running operation -> ignored; the first result is unchanged, exactly one done pulse occurs, and busy stays high through E8.
REQ-031 rst=1 asserted at edge E4 of a running operation -> at the next cycle busy=0, done=0 and DIFF/BOUT/OVF=0; no done pulse follows; a new start then completes correctly.
REQ-032 Back-to-back operation with start held at 1 -> done pulses exactly every 10 cycles with correct results for each operand pair.
